// File: rtl/pe_output_collector_pkg.sv
// pe_output_collector_pkg: shared defaults and FSM encodings for the PE output collector
package pe_output_collector_pkg;
  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_NUM_COLS = 4;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_COL_W    = $clog2(DEF_NUM_COLS);
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pe_row_fifo.sv
// pe_row_fifo: circular DEPTH-entry row buffer with push/pop/count/full/empty
module pe_row_fifo
  import pe_output_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end
  // row storage needs no reset; only occupied slots are ever read out
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/pe_output_collector.sv
// pe_output_collector: buffers PE result rows and drains them as a column-serial byte stream (optional OUT_COLLECT_RELU_EN clamps negative bytes to zero)
module pe_output_collector
  import pe_output_collector_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int COL_W    = $clog2(NUM_COLS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cap_valid,
  input  logic [NUM_COLS*DWIDTH-1:0] cap_data,
  output logic                       cap_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DWIDTH-1:0]          out_data,
  output logic [COL_W-1:0]           out_col,
  output logic                       out_last,
  output logic                       overflow
);
  localparam int ROW_W = NUM_COLS * DWIDTH;
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  state_t state;
  logic [ROW_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic full, empty, push, pop, hs;
  logic [DWIDTH-1:0] raw;
  assign cap_ready = !full;
  assign push      = cap_valid && cap_ready;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && out_last;
  pe_row_fifo #(.WIDTH(ROW_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .wr_data(cap_data),
    .rd_data(head), .count(count), .full(full), .empty(empty)
  );
  // output mux: head row is stable until the last-column pop, so the byte holds under back-pressure
  always_comb begin
    raw = head[int'(out_col)*DWIDTH +: DWIDTH];
`ifdef OUT_COLLECT_RELU_EN
    out_data = (out_valid && !raw[DWIDTH-1]) ? raw : '0;
`else
    out_data = out_valid ? raw : '0;
`endif
  end
  // sticky overflow on any capture attempt while the buffer is full
  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else if (cap_valid && !cap_ready) overflow <= 1'b1;
  end
  // serializer: IDLE waits for a row, EMIT walks the columns and chains rows without a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (state == IDLE) begin
      if (!empty) begin
        state     <= EMIT;
        out_valid <= 1'b1;
        out_col   <= '0;
        out_last  <= NUM_COLS == 1;
      end
    end else if (hs) begin
      if (!out_last) begin
        out_col  <= out_col + 1'b1;
        out_last <= (out_col + 1'b1) == LAST_COL;
      end else begin
        out_col  <= '0;
        out_last <= NUM_COLS == 1;
        if (count == CNT_W'(1) && !push) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule
